// File: rtl/divider.sv
// rtl/divider.sv - 32/16 and 16/8 restoring divider, unsigned (DIV) and signed (IDIV).
// Overflow is caught before iterating; signed results are corrected in one fixup cycle.
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        complete,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, WORKING, FIXUP, DONE} state_t;

  state_t      state_q;
  logic [15:0] acc_q, low_q, quo_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        byte_q, signed_q, dvd_neg_q, dvs_neg_q;
  logic [15:0] quotient_q, remainder_q;
  logic        busy_q, complete_q, error_q;

  logic        dvd_neg, dvs_neg, pre_fault;
  logic [31:0] word_abs;
  logic [15:0] byte_abs, dvs_abs, hi_in, lo_in;
  logic [16:0] shifted, diff;
  logic        take;
  logic [15:0] acc_d, lim, q_fix, r_fix, mask;
  logic        range_fault;

  // Magnitudes of the incoming operands and the overflow pre-check.
  always_comb begin
    dvd_neg  = is_signed & (is_8_bit ? dividend[15] : dividend[31]);
    dvs_neg  = is_signed & (is_8_bit ? divisor[7] : divisor[15]);
    word_abs = dvd_neg ? (32'd0 - dividend) : dividend;
    byte_abs = dvd_neg ? (16'd0 - dividend[15:0]) : dividend[15:0];
    if (is_8_bit) begin
      hi_in   = {8'd0, byte_abs[15:8]};
      lo_in   = {byte_abs[7:0], 8'd0};
      dvs_abs = {8'd0, dvs_neg ? (8'd0 - divisor[7:0]) : divisor[7:0]};
    end else begin
      hi_in   = word_abs[31:16];
      lo_in   = word_abs[15:0];
      dvs_abs = dvs_neg ? (16'd0 - divisor) : divisor;
    end
    pre_fault = (dvs_abs == 16'd0) || (hi_in >= dvs_abs);
  end

  // One restoring step plus the signed correction of the final magnitudes.
  always_comb begin
    shifted     = {acc_q, low_q[15]};
    diff        = shifted - {1'b0, dvs_q};
    take        = shifted >= {1'b0, dvs_q};
    acc_d       = take ? diff[15:0] : shifted[15:0];
    lim         = byte_q ? 16'h007F : 16'h7FFF;
    mask        = byte_q ? 16'h00FF : 16'hFFFF;
    range_fault = signed_q && (quo_q > lim);
    q_fix       = ((dvd_neg_q ^ dvs_neg_q) ? (16'd0 - quo_q) : quo_q) & mask;
    r_fix       = (dvd_neg_q ? (16'd0 - acc_q) : acc_q) & mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      low_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q     <= hi_in;
            low_q     <= lo_in;
            quo_q     <= '0;
            dvs_q     <= dvs_abs;
            cnt_q     <= is_8_bit ? 5'd8 : 5'd16;
            byte_q    <= is_8_bit;
            signed_q  <= is_signed;
            dvd_neg_q <= dvd_neg;
            dvs_neg_q <= dvs_neg;
            if (pre_fault) begin
              state_q     <= DONE;
              complete_q  <= 1'b1;
              error_q     <= 1'b1;
              quotient_q  <= '0;
              remainder_q <= '0;
            end else begin
              state_q <= WORKING;
              busy_q  <= 1'b1;
            end
          end
        end
        WORKING: begin
          acc_q <= acc_d;
          low_q <= {low_q[14:0], 1'b0};
          quo_q <= {quo_q[14:0], take};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= FIXUP;
        end
        FIXUP: begin
          state_q     <= DONE;
          busy_q      <= 1'b0;
          complete_q  <= 1'b1;
          error_q     <= range_fault;
          quotient_q  <= range_fault ? 16'd0 : q_fix;
          remainder_q <= range_fault ? 16'd0 : r_fix;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign complete  = complete_q;
  assign error     = error_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider against an arithmetic model.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset, start, is_8_bit, is_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient, remainder;
  logic        busy, complete, error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_q = '0, last_r = '0;
  logic        last_e = 1'b0;

  always #5 clk = ~clk;

  divider dut (
    .clk(clk), .reset(reset), .start(start), .is_8_bit(is_8_bit), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .complete(complete), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected results from plain integer division with truncation toward zero.
  task automatic model(input logic b8, input logic sg, input logic [31:0] dd, input logic [15:0] dv,
                       output logic [15:0] q, output logic [15:0] r, output logic e, output int lat);
    longint d, v, qq, rr, aq, m;
    int n;
    n = b8 ? 8 : 16;
    m = (longint'(1) << n) - 1;
    if (sg) begin
      d = b8 ? longint'($signed(dd[15:0])) : longint'($signed(dd));
      v = b8 ? longint'($signed(dv[7:0])) : longint'($signed(dv));
    end else begin
      d = b8 ? longint'(dd[15:0]) : longint'(dd);
      v = b8 ? longint'(dv[7:0]) : longint'(dv);
    end
    qq = 0;
    rr = 0;
    if (v == 0) begin
      e = 1'b1;
      lat = 1;
    end else begin
      qq = d / v;
      rr = d % v;
      aq = (qq < 0) ? -qq : qq;
      if (aq > m) begin
        e = 1'b1;
        lat = 1;
      end else begin
        lat = n + 2;
        e = sg && (aq > (m >> 1));
      end
    end
    q = e ? 16'd0 : 16'(qq & m);
    r = e ? 16'd0 : 16'(rr & m);
  endtask

  task automatic do_div(input string tag, input logic b8, input logic sg,
                        input logic [31:0] dd, input logic [15:0] dv);
    logic [15:0] eq, er;
    logic        ee, hold_ok;
    int          lat, k;
    model(b8, sg, dd, dv, eq, er, ee, lat);
    @(negedge clk);
    start = 1'b1; is_8_bit = b8; is_signed = sg; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0;
    hold_ok = 1'b1;
    k = 1;
    while (!complete && k < 40) begin
      if (!busy || quotient !== last_q || remainder !== last_r || error !== last_e) hold_ok = 1'b0;
      start     = 1'($urandom_range(0, 1));
      is_8_bit  = 1'($urandom_range(0, 1));
      is_signed = 1'($urandom_range(0, 1));
      dividend  = $urandom;
      divisor   = 16'($urandom);
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " hold"}, hold_ok, 1'b1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " error"}, error, ee);
    check({tag, " busy@done"}, busy, 1'b0);
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle after"}, {busy, complete}, 2'b00);
    last_q = eq;
    last_r = er;
    last_e = ee;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b8, sg, seen;
    logic [31:0] dd;
    logic [15:0] dv;
    reset = 1'b1; start = 1'b0; is_8_bit = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("reset outputs", {quotient, remainder, busy, complete, error}, 35'd0);
    reset = 1'b0;
    start = 1'b0;

    do_div("word div", 1'b0, 1'b0, 32'h0000_0064, 16'h0007);
    do_div("byte div", 1'b1, 1'b0, 32'h0000_00FF, 16'h0010);
    do_div("word idiv", 1'b0, 1'b1, 32'hFFFF_FF9C, 16'h0007);
    do_div("div0 word", 1'b0, 1'b0, 32'h0000_1234, 16'h0000);
    do_div("div0 byte s", 1'b1, 1'b1, 32'h0000_0012, 16'hFF00);
    do_div("word ovf", 1'b0, 1'b0, 32'h0007_0000, 16'h0007);
    do_div("byte idiv -128", 1'b1, 1'b1, 32'h0000_FF80, 16'h0001);
    do_div("word idiv max", 1'b0, 1'b1, 32'h0000_7FFF, 16'h0001);
    do_div("word div prev", 1'b0, 1'b0, 32'h0000_1234, 16'h0011);

    // Abort a running word divide with reset.
    @(negedge clk);
    start = 1'b1; is_8_bit = 1'b0; is_signed = 1'b0; dividend = 32'h0000_0064; divisor = 16'h0007;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (complete) seen = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset abort outputs", {quotient, remainder, busy, complete, error}, 35'd0);
    repeat (20) begin
      if (complete) seen = 1'b1;
      @(negedge clk);
    end
    check("reset abort no complete", seen, 1'b0);
    last_q = '0; last_r = '0; last_e = 1'b0;
    do_div("after reset", 1'b0, 1'b0, 32'h0000_0064, 16'h0007);

    for (int i = 0; i < 60; i++) begin
      b8 = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      dd = $urandom >> $urandom_range(0, 31);
      if (sg && $urandom_range(0, 1) == 1) dd = 32'd0 - dd;
      dv = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) dv = '0;
      if (sg && $urandom_range(0, 1) == 1) dv = 16'd0 - dv;
      do_div($sformatf("rand%0d", i), b8, sg, dd, dv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
